iob_cache_line_writeback: RTL
=============================

Name: iob_cache_line_writeback

Overview:
- Write-direction counterpart of the cache line-fetch channel.
- On a dirty-line eviction, it reads the victim line word-by-word from the cache data memory and writes it to the back-end native memory interface using a valid/ack handshake.
- Sits between the cache control FSM, the data memory read port and the back-end write port.

Parameters:
- FE_ADDR_W, `IOB_CACHE_ADDR_W (24): front-end byte address width.
- FE_DATA_W, `IOB_CACHE_DATA_W (32): front-end word width.
- BE_ADDR_W, `IOB_CACHE_BE_ADDR_W (24): back-end byte address width.
- BE_DATA_W, `IOB_CACHE_BE_DATA_W (32): back-end word width; a multiple of FE_DATA_W.
- WORD_OFFSET_W, `IOB_CACHE_WORD_OFFSET_W (3): log2 of FE words per line.
- BE_NBYTES, BE_DATA_W/8 (derived): back-end bytes per beat.
- BE_NBYTES_W, $clog2(BE_NBYTES) (derived): byte-offset width.
- LINE2BE_W, WORD_OFFSET_W-$clog2(BE_DATA_W/FE_DATA_W) (derived): log2 of beats per line; 0 is legal.
- CNT_W, (LINE2BE_W>0)?LINE2BE_W:1 (derived): counter and port width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-high.
- wb_valid_i  in  1  start request; sampled only when wb_ready_o=1.
- wb_addr_i  in  FE_ADDR_W-(BE_NBYTES_W+LINE2BE_W)  line address (tag+index) of the victim line.
- wb_ready_o  out  1  high only in IDLE.
- wb_done_o  out  1  one-cycle pulse when the last beat is acknowledged.
- line_rd_en_o  out  1  data memory read enable.
- line_rd_addr_o  out  CNT_W  beat index within the line; tied to 0 when LINE2BE_W=0.
- line_rdata_i  in  BE_DATA_W  data memory read data; valid exactly 1 cycle after line_rd_en_o.
- be_valid_o  out  1  back-end write request.
- be_addr_o  out  BE_ADDR_W  {zero-extend, addr_q, cnt, BE_NBYTES_W'b0}; the cnt field is absent when LINE2BE_W=0.
- be_wdata_o  out  BE_DATA_W  write data.
- be_wstrb_o  out  BE_NBYTES  all ones during SEND, 0 otherwise.
- be_ack_i  in  1  back-end acknowledge.

Behaviour:
- Reset values:
  - Registers: state=IDLE, cnt=0, addr_q=0, wdata_q=0.
  - Outputs: wb_ready_o=1; wb_done_o, line_rd_en_o, be_valid_o all 0; be_wstrb_o=0; be_wdata_o=0.
- All outputs are decoded from registers only. No combinational path from be_ack_i or wb_valid_i to any output.
- IDLE:
  - wb_ready_o=1.
  - If wb_valid_i: addr_q<=wb_addr_i, cnt<=0, go READ.
- READ:
  - line_rd_en_o=1, line_rd_addr_o=cnt.
  - Go CAPTURE.
- CAPTURE:
  - wdata_q<=line_rdata_i.
  - Go SEND.
- SEND:
  - be_valid_o=1; be_wdata_o, be_addr_o and be_wstrb_o held stable until ack.
  - On be_ack_i, if cnt==all-ones (or LINE2BE_W=0): cnt<=0, go DONE.
  - Otherwise on be_ack_i: cnt<=cnt+1 (wrap impossible), go READ.
  - Without ack: stay in SEND.
- DONE:
  - wb_done_o=1 for one cycle.
  - Go IDLE.
- Timing:
  - Per beat: 3 cycles plus ack wait.
  - Zero-wait line: 3*2^LINE2BE_W+2 cycles from the wb_valid_i sample to the return to IDLE.
- Boundary conditions:
  - be_ack_i in the first SEND cycle is accepted.
  - be_ack_i outside SEND is ignored.
  - wb_valid_i while not IDLE (including DONE) is ignored.
  - wb_addr_i changes after the start have no effect.
- reset_i mid-burst: immediate return to IDLE; be_valid_o and line_rd_en_o drop asynchronously; the partial line is abandoned and wb_done_o is not asserted.
- be_wdata_o=wdata_q in all states; it holds its last value outside SEND.

Decomposition:
- Shared header iob_cache_conf.vh: parameter defaults.
- State encodings (IDLE=0, READ=1, CAPTURE=2, SEND=3, DONE=4; 3 bits) are module-local localparams.
- LINE2BE_W=0 and LINE2BE_W>0 are handled with a generate branch, as in the read channel.
- No sub-module; counter and FSM stay in this module.

Test Plan:
All scenarios use FE_ADDR_W=24, BE=FE=32, WORD_OFFSET_W=2 (LINE2BE_W=2). Data memory model returns 0xA0+idx.
- Zero-wait burst: wb_valid_i at t0 with wb_addr_i=20'h0ABCD.
  - be_addr_o = 0x0ABCD0, 0x0ABCD4, 0x0ABCD8, 0x0ABCDC, with wdata 0xA0..0xA3.
  - SEND cycles at t3, t6, t9, t12; wb_done_o at t13; wb_ready_o=1 at t14.
- Back-pressure: ack withheld 5 cycles on beat 1 -> be_valid_o, be_addr_o=0x0ABCD4 and wdata=0xA1 stay stable; completion is 5 cycles later.
- Spurious inputs: be_ack_i pulsed during READ/CAPTURE and wb_valid_i pulsed mid-burst -> no counter advance, no restart, 4 beats total.
- Reset at the beat-2 SEND -> be_valid_o=0 the same cycle; wb_done_o never asserted. A new request then restarts at beat 0.
- LINE2BE_W=0 build (WORD_OFFSET_W=0): single beat with be_addr_o={addr,2'b00}; wb_done_o 4 cycles after start.
- Back-to-back: wb_valid_i held high -> second burst is sampled only when IDLE is re-entered, with no overlap.

Source files
------------

// File: rtl/iob_cache_line_writeback_pkg.sv
// iob_cache_line_writeback_pkg: default widths and FSM state encoding for the line write-back channel
package iob_cache_line_writeback_pkg;
  localparam int IOB_CACHE_ADDR_W = 24;
  localparam int IOB_CACHE_DATA_W = 32;
  localparam int IOB_CACHE_BE_ADDR_W = 24;
  localparam int IOB_CACHE_BE_DATA_W = 32;
  localparam int IOB_CACHE_WORD_OFFSET_W = 3;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } wb_state_t;
endpackage

// File: rtl/iob_cache_line_writeback_if.sv
// iob_cache_line_writeback_if: back-end native write port (valid/ack handshake)
interface iob_cache_line_writeback_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  localparam int NBYTES = DATA_W / 8;
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [NBYTES-1:0] wstrb;
  logic              ack;
  modport master (output valid, addr, wdata, wstrb, input ack);
  modport slave (input valid, addr, wdata, wstrb, output ack);
endinterface

// File: rtl/iob_cache_line_writeback.sv
// iob_cache_line_writeback: streams an evicted dirty line from data memory to the back-end write port
module iob_cache_line_writeback
  import iob_cache_line_writeback_pkg::*;
#(
  parameter int FE_ADDR_W = IOB_CACHE_ADDR_W,
  parameter int FE_DATA_W = IOB_CACHE_DATA_W,
  parameter int BE_ADDR_W = IOB_CACHE_BE_ADDR_W,
  parameter int BE_DATA_W = IOB_CACHE_BE_DATA_W,
  parameter int WORD_OFFSET_W = IOB_CACHE_WORD_OFFSET_W,
  localparam int BE_NBYTES = BE_DATA_W / 8,
  localparam int BE_NBYTES_W = $clog2(BE_NBYTES),
  localparam int LINE2BE_W = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W),
  localparam int CNT_W = (LINE2BE_W > 0) ? LINE2BE_W : 1,
  localparam int LINE_ADDR_W = FE_ADDR_W - (BE_NBYTES_W + LINE2BE_W)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   wb_valid_i,
  input  logic [LINE_ADDR_W-1:0] wb_addr_i,
  output logic                   wb_ready_o,
  output logic                   wb_done_o,
  output logic                   line_rd_en_o,
  output logic [CNT_W-1:0]       line_rd_addr_o,
  input  logic [BE_DATA_W-1:0]   line_rdata_i,
  iob_cache_line_writeback_if.master be
);
  wb_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [LINE_ADDR_W-1:0] addr_q;
  logic [BE_DATA_W-1:0] wdata_q;
  logic last;
  // in the single-beat build cnt never leaves 0, so the read address is constant 0
  assign last = (LINE2BE_W == 0) || (&cnt);
  assign line_rd_addr_o = cnt;
  assign be.wdata = wdata_q;
  if (LINE2BE_W > 0) begin : g_multi
    assign be.addr = BE_ADDR_W'({addr_q, cnt, {BE_NBYTES_W{1'b0}}});
  end else begin : g_single
    assign be.addr = BE_ADDR_W'({addr_q, {BE_NBYTES_W{1'b0}}});
  end
  // write-back sequencer: READ issues the memory read, CAPTURE latches it, SEND holds it until ack
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wb_ready_o <= 1'b1;
      wb_done_o <= 1'b0;
      line_rd_en_o <= 1'b0;
      be.valid <= 1'b0;
      be.wstrb <= '0;
    end else begin
      case (state)
        IDLE: if (wb_valid_i) begin
          addr_q <= wb_addr_i;
          cnt <= '0;
          wb_ready_o <= 1'b0;
          line_rd_en_o <= 1'b1;
          state <= READ;
        end
        READ: begin
          line_rd_en_o <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          wdata_q <= line_rdata_i;
          be.valid <= 1'b1;
          be.wstrb <= '1;
          state <= SEND;
        end
        SEND: if (be.ack) begin
          be.valid <= 1'b0;
          be.wstrb <= '0;
          if (last) begin
            cnt <= '0;
            wb_done_o <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
            line_rd_en_o <= 1'b1;
            state <= READ;
          end
        end
        DONE: begin
          wb_done_o <= 1'b0;
          wb_ready_o <= 1'b1;
          state <= IDLE;
        end
        default: begin
          wb_done_o <= 1'b0;
          line_rd_en_o <= 1'b0;
          be.valid <= 1'b0;
          be.wstrb <= '0;
          wb_ready_o <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
